// File: rtl/rv_ctl_ws.sv
// Multi-cycle RV32 subset control FSM with memory wait states and a sticky
// timeout fault; the datapath select encodings mirror the shared params.inc values.
module rv_ctl_ws #(
    parameter int MEM_TIMEOUT = 16,
    parameter bit EN_BNE      = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        memrw,
    output logic        pcsource,
    output logic        pcwrite,
    output logic        pccen,
    output logic        irwrite,
    output logic        regwen,
    output logic        mdrwrite,
    output logic [1:0]  wbsel,
    output logic [1:0]  immsel,
    output logic [1:0]  asel,
    output logic [1:0]  bsel,
    output logic [3:0]  alusel,
    output logic        fault,
    output logic [3:0]  state_o
);
    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_ADDR = 4'd2, S_MEM_RD = 4'd3,
                           S_MEM_WB = 4'd4, S_MEM_WR = 4'd5, S_RTYPE = 4'd6, S_ITYPE = 4'd7,
                           S_ALU_WB = 4'd8, S_BRANCH = 4'd9, S_JAL = 4'd10, S_JALR = 4'd11,
                           S_FAULT = 4'd12;

    localparam logic       PC_INC = 1'b0, PC_ALU = 1'b1;
    localparam logic [1:0] WB_ALUOUT = 2'd0, WB_MDR = 2'd1, WB_PC = 2'd2;
    localparam logic [1:0] IMM_L = 2'd0, IMM_S = 2'd1, IMM_B = 2'd2;
    localparam logic [1:0] ALUA_REG = 2'd0, ALUA_PCC = 2'd1;
    localparam logic [1:0] ALUB_REG = 2'd0, ALUB_IMM = 2'd1;
    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1;

    localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_IMM = 7'b0010011,
                           OP_REG = 7'b0110011, OP_BRANCH = 7'b1100011, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111;

    logic [3:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [8:0] cnt_inc;
    logic       timeout;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       is_lw, is_sw, is_addi, is_alu, is_beq, is_bne, is_jal, is_jalr;
    logic       unused_instr_bits;

    assign opcode  = instr[6:0];
    assign funct3  = instr[14:12];
    assign is_lw   = (opcode == OP_LOAD)   && (funct3 == 3'b010);
    assign is_sw   = (opcode == OP_STORE)  && (funct3 == 3'b010);
    assign is_addi = (opcode == OP_IMM)    && (funct3 == 3'b000);
    assign is_alu  = (opcode == OP_REG);
    assign is_beq  = (opcode == OP_BRANCH) && (funct3 == 3'b000);
    assign is_bne  = EN_BNE && (opcode == OP_BRANCH) && (funct3 == 3'b001);
    assign is_jal  = (opcode == OP_JAL);
    assign is_jalr = (opcode == OP_JALR)   && (funct3 == 3'b000);
    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

    // Timeout fires on the wait cycle whose increment would reach MEM_TIMEOUT.
    assign cnt_inc = {1'b0, cnt_q} + 9'd1;
    assign timeout = (cnt_inc == 9'(MEM_TIMEOUT));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mem_req  = 1'b0;
        memrw    = 1'b0;
        pcsource = PC_INC;
        pcwrite  = 1'b0;
        pccen    = 1'b0;
        irwrite  = 1'b0;
        regwen   = 1'b0;
        mdrwrite = 1'b0;
        wbsel    = WB_PC;
        immsel   = IMM_B;
        asel     = ALUA_REG;
        bsel     = ALUB_REG;
        alusel   = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    irwrite = 1'b1;
                    pcwrite = 1'b1;
                    pccen   = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d = S_FAULT;
                end
            end
            S_DECODE: begin
                asel = ALUA_PCC;
                bsel = ALUB_IMM;
                if (is_lw || is_sw)         state_d = S_ADDR;
                else if (is_addi)           state_d = S_ITYPE;
                else if (is_alu)            state_d = S_RTYPE;
                else if (is_beq || is_bne)  state_d = S_BRANCH;
                else if (is_jal)            state_d = S_JAL;
                else if (is_jalr)           state_d = S_JALR;
                else                        state_d = S_FETCH;
            end
            S_ADDR: begin
                bsel    = ALUB_IMM;
                immsel  = is_sw ? IMM_S : IMM_L;
                state_d = is_sw ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    mdrwrite = 1'b1;
                    state_d  = S_MEM_WB;
                end else if (timeout) begin
                    state_d = S_FAULT;
                end
            end
            S_MEM_WB: begin
                wbsel   = WB_MDR;
                regwen  = 1'b1;
                state_d = S_FETCH;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                memrw   = 1'b1;
                if (mem_ready)    state_d = S_FETCH;
                else if (timeout) state_d = S_FAULT;
            end
            S_RTYPE: begin
                alusel  = {funct3, instr[30]};
                state_d = S_ALU_WB;
            end
            S_ITYPE: begin
                bsel    = ALUB_IMM;
                immsel  = IMM_L;
                state_d = S_ALU_WB;
            end
            S_ALU_WB: begin
                wbsel   = WB_ALUOUT;
                regwen  = 1'b1;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                alusel   = ALU_SUB;
                pcsource = PC_ALU;
                pcwrite  = is_beq ? zero : ~zero;
                state_d  = S_FETCH;
            end
            S_JAL, S_JALR: begin
                asel     = (state_q == S_JAL) ? ALUA_PCC : ALUA_REG;
                immsel   = (state_q == S_JAL) ? IMM_B : IMM_L;
                bsel     = ALUB_IMM;
                pcsource = PC_ALU;
                pcwrite  = 1'b1;
                regwen   = 1'b1;
                wbsel    = WB_PC;
                state_d  = S_FETCH;
            end
            default: state_d = S_FAULT;
        endcase
        // Any state change restarts the wait count for the next memory phase.
        if (state_d != state_q)
            cnt_d = '0;
        else if (mem_req && !mem_ready)
            cnt_d = cnt_inc[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign fault   = (state_q == S_FAULT);
    assign state_o = state_q;
endmodule

// File: doc/rv_ctl_ws.md
RV_CTL_WS -- requirements
Module: rv_ctl_ws

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16, SHALL set the maximum cycles a memory wait state may last before fault; legal range 1..255.
REQ-002 Parameter EN_BNE, default 1, SHALL enable BNE decoding; when 0, BNE SHALL decode as unimplemented.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 instr  in  32  current IR contents; opcode_funct3 = {instr[6:0], instr[14:12]}.
REQ-006 zero  in  1  ALU zero flag.
REQ-007 mem_ready  in  1  memory completion strobe for the current request.
REQ-008 mem_req  out  1  memory request; held high until mem_ready.
REQ-009 memrw  out  1  1 = write, 0 = read; valid while mem_req=1.
REQ-010 pcsource, pcwrite, pccen, irwrite, regwen, mdrwrite  out  1 each  datapath strobes, with existing codebase meaning.
REQ-011 wbsel, immsel, asel, bsel  out  2 each  datapath selects, using the shared params.inc encodings.
REQ-012 alusel  out  4  ALU operation, using params.inc encodings.
REQ-013 fault  out  1  sticky memory-timeout indication.
REQ-014 state_o  out  4  current state encoding, for debug.

Function
REQ-015 States and encodings SHALL be: FETCH=0, DECODE=1, ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, RTYPE_ALU=6, ITYPE_ALU=7, ALU_WB=8, BRANCH=9, JAL_EXEC=10, JALR_EXEC=11, FAULT=12.
REQ-016 Every output SHALL default to 0, PC_INC, WB_PC, IMM_B, ALUA_REG, ALUB_REG or ALU_ADD as applicable, unless a state below asserts it.
REQ-017 FETCH behaviour:
- mem_req=1, memrw=0.
- On mem_ready: irwrite=1, pcwrite=1, pccen=1, pcsource=PC_INC in that same cycle, then go to DECODE.
- Otherwise stay in FETCH.
REQ-018 DECODE SHALL drive asel=ALUA_PCC, bsel=ALUB_IMM, immsel=IMM_B, alusel=ALU_ADD.
REQ-019 DECODE next state:
- LW or SW -> ADDR
- ADDI -> ITYPE_ALU
- ALU -> RTYPE_ALU
- BEQ, or BNE when EN_BNE=1 -> BRANCH
- JAL -> JAL_EXEC
- JALR -> JALR_EXEC
- anything else -> FETCH, with no strobes.
REQ-020 ADDR SHALL drive asel=ALUA_REG, bsel=ALUB_IMM, alusel=ALU_ADD, immsel=IMM_L for LW and IMM_S for SW, then go to MEM_RD (LW) or MEM_WR (SW).
REQ-021 MEM_RD SHALL drive mem_req=1, memrw=0, and on mem_ready assert mdrwrite=1 and go to MEM_WB.
REQ-022 MEM_WB SHALL drive wbsel=WB_MDR, regwen=1, then go to FETCH.
REQ-023 MEM_WR SHALL drive mem_req=1, memrw=1, and on mem_ready go to FETCH.
REQ-024 RTYPE_ALU SHALL drive alusel={instr[14:12], instr[30]} with register operands, then go to ALU_WB.
REQ-025 ITYPE_ALU SHALL drive asel=ALUA_REG, bsel=ALUB_IMM, immsel=IMM_L, alusel=ALU_ADD, then go to ALU_WB.
REQ-026 ALU_WB SHALL drive wbsel=WB_ALUOUT, regwen=1, then go to FETCH.
REQ-027 BRANCH behaviour:
- Drive alusel=ALU_SUB with register operands and pcsource=PC_ALU.
- pcwrite = zero for BEQ, ~zero for BNE.
- Then go to FETCH.
REQ-028 JAL_EXEC SHALL drive asel=ALUA_PCC, bsel=ALUB_IMM, alusel=ALU_ADD, pcsource=PC_ALU, pcwrite=1, regwen=1, wbsel=WB_PC, then go to FETCH.
REQ-029 JALR_EXEC SHALL drive the same outputs as JAL_EXEC, except asel=ALUA_REG and immsel=IMM_L.
REQ-030 Wait counter behaviour:
- An 8-bit counter SHALL clear on entry to FETCH, MEM_RD and MEM_WR.
- It SHALL increment each cycle spent there without mem_ready.
- When the count reaches MEM_TIMEOUT with mem_ready still low, the next state SHALL be FAULT.
REQ-031 mem_ready arriving in the same cycle the counter reaches MEM_TIMEOUT SHALL complete normally; completion takes priority over timeout.
REQ-032 FAULT SHALL hold fault=1 and all strobes at 0, and SHALL remain in FAULT until rst.
REQ-033 mem_ready while mem_req=0 SHALL be ignored.
REQ-034 Latencies with zero wait states SHALL be (cycles, including FETCH and DECODE):
- LW 5, SW 4
- R-type 4, ADDI 4
- branch 3, JAL 3, JALR 3

Reset
REQ-035 With rst high at a clock edge, the next state SHALL be FETCH, the counter SHALL be 0 and fault SHALL be 0, regardless of current state.
REQ-036 Reset SHALL abort any in-flight request; mem_req SHALL be 1 on the first cycle after reset, since the block is in FETCH.

Verification
REQ-037 LW with mem_ready asserted the cycle after mem_req -> states 0,1,2,3,4,0; regwen=1 and wbsel=WB_MDR only in state 4.
REQ-038 SW with mem_ready delayed 3 cycles in MEM_WR -> memrw=1 and mem_req=1 held for 4 cycles; no regwen at any point.
REQ-039 BNE (EN_BNE=1) with zero=0 -> pcwrite=1 in BRANCH; with zero=1 -> pcwrite=0; with EN_BNE=0 -> DECODE goes to FETCH.
REQ-040 MEM_TIMEOUT=4 and mem_ready never asserted in FETCH -> FAULT entered after the 4th wait cycle, fault=1 sticky; rst=1 returns to FETCH with fault=0.
REQ-041 mem_ready in exactly the timeout cycle of MEM_RD -> mdrwrite=1, next state MEM_WB, fault stays 0.
REQ-042 rst asserted mid-MEM_WR -> the next cycle is FETCH with memrw=0 and no write completed.
